h80bus_timer: RTL and testbench
===============================

# h80bus_timer

Memory-mapped down-counting timer that acts as a responder on the h80bus I/O space, alongside the existing memory and I/O responders. The CPU initiates reads and writes; this block decodes its address window, inserts read wait states through `wait_n`, and drives `bus_data` only during its own read cycles. The block gives the CPU a programmable periodic tick with a sticky expiry flag and a level interrupt output.

## Interface
- `BUS_ADDR_WIDTH`, 16, bus address width.
- `BUS_CMD_WIDTH`, 3, bus command width; encodings are `BUS_CMD_READ` and `BUS_CMD_WRITE` from the shared bus header.
- `BUS_DATA_WIDTH`, 32, bus data width; all registers are this wide, but PRESCALE uses only bits [15:0].
- `BASE_ADDR`, 16'h0010, window base; must be 16-aligned.
- `RD_WAIT_STATES`, 1, number of wait cycles per read (≥1).

Ports:
- `clk` input 1: the single clock. It is connected to `~clk` of the CPU, as the other responders are.
- `reset_n` input 1: asynchronous, active-low reset.
- `en_n` input 1: I/O request, active low (the `iorq_n` path).
- `bus_addr` input BUS_ADDR_WIDTH: address.
- `bus_cmd` input BUS_CMD_WIDTH: command.
- `bus_data` inout BUS_DATA_WIDTH: write data in, read data out; high-Z otherwise.
- `wait_n` output 1: low stretches the current access. It is wired-AND with the other responders.
- `irq` output 1: level interrupt.

## Operation
- **Select.** `sel = !en_n && bus_addr[W-1:4] == BASE_ADDR[W-1:4]`. The offset is `bus_addr[3:0]`.
- **Register map.**
  - 0 CTRL: bit0 EN, bit1 AUTO, bit2 IE; other bits read 0.
  - 1 STATUS: bit0 EXP, sticky; writing 1 clears it.
  - 2 LOAD.
  - 3 COUNT: write sets the count; read returns the live count.
  - 4 PRESCALE: [15:0].
  - Offsets 5–15 read 0; writes to them are ignored.
- **Bus FSM states.** IDLE, RD_WAIT, RD_DRIVE, DONE.
  - IDLE, `sel` and WRITE: the register updates on this edge, then go to DONE. `wait_n` stays 1.
  - IDLE, `sel` and READ: load `wcnt = RD_WAIT_STATES-1`, go to RD_WAIT.
  - RD_WAIT: if `wcnt == 0`, capture the addressed register into `rdata` and go to RD_DRIVE; otherwise decrement `wcnt`.
  - RD_DRIVE: go to DONE.
  - DONE: hold until `en_n` is 1, then go to IDLE.
  - `en_n` = 1 in any non-IDLE state returns the FSM to IDLE. This abort cancels any pending capture.
  - A command that is neither READ nor WRITE is treated as a no-op. The FSM goes to DONE with no wait states.
- **`wait_n` (combinational).** `wait_n = 0` when `sel`, the command is READ, and the state is IDLE or RD_WAIT. Otherwise it is 1. It is 1 whenever the block is not selected.
- **`bus_data` drive.** The block drives `rdata` when `sel`, the command is READ, and the state is RD_DRIVE or DONE. Otherwise `bus_data` is high-Z.
- **Prescaler.** With EN=1, `psc` counts 0..PRESCALE. At `psc == PRESCALE`, `psc` returns to 0 and a tick is generated. PRESCALE=0 gives a tick every cycle. With EN=0, `psc` is held at 0.
- **Counter on each tick.**
  - COUNT≠0: decrement COUNT.
  - COUNT==0: set EXP. If AUTO, COUNT←LOAD. Otherwise EN←0 and COUNT stays 0.
- **Interrupt.** `irq = EXP & IE`, registered.
- **Simultaneous events.**
  - A bus write to COUNT or CTRL in the same cycle as a tick: the write wins, and the tick's effect on that register is discarded.
  - EXP set and a write-1-clear in the same cycle: the set wins.
  - Writing CTRL.EN 0→1 clears `psc`.
- **Arithmetic.** All counters are unsigned and mod 2^W. COUNT never decrements below 0.

## Timing
- **Reset.** Asynchronous reset (`reset_n` = 0) sets:
  - All registers, `psc`, `wcnt` and `rdata` to 0.
  - The FSM to IDLE.
  - `irq` = 0.
  - `wait_n` = 1 and `bus_data` = Z. These are combinational and follow from state IDLE.
  - A reset during an access aborts it immediately.
- **Write latency.** Write data is sampled on the first `clk` edge with `sel`. The register is visible from the next cycle.
- **Read latency.** `wait_n` is low for `RD_WAIT_STATES + 1` edges. Data is valid from the cycle `wait_n` rises until `en_n` deasserts.
- **Read value.** COUNT read returns the value at the capture edge, not at request time.
- **`irq` latency.** `irq` rises one cycle after EXP sets.

## Test plan
- **Reset.** Assert `reset_n`=0 mid-read → `wait_n`=1, `bus_data`=Z immediately, `irq`=0, and every register reads 0 after release.
- **Write/read round trip.** Write LOAD=32'h1234_5678 → `wait_n` never low. A read then sees exactly 2 cycles of `wait_n`=0 and returns 32'h1234_5678. Offset 9 reads 0.
- **One-shot.** PRESCALE=0, COUNT=3, CTRL=EN|IE → EXP sets on the 4th tick, `irq`=1 one cycle later, EN reads 0, COUNT stays 0.
- **Auto-reload.** PRESCALE=1, LOAD=2, COUNT=0, CTRL=EN|AUTO → EXP set every 6 cycles. Writing STATUS=1 clears `irq`; a collision of set and clear on the same cycle leaves EXP=1.
- **Write vs tick collision.** Write COUNT=100 on the cycle a tick occurs → COUNT reads 100, not 99.
- **Address window.** An access with `bus_addr`=16'h0020 or `en_n`=1 → `wait_n`=1, `bus_data`=Z, no register change. Aborting a read (`en_n`=1 during RD_WAIT) returns the FSM to IDLE.

Source files
------------

// File: rtl/h80bus_timer_if.sv
// h80bus responder interface: I/O request, address, command and the
// wired-AND wait handshake. The bidirectional data bus is carried as a
// separate inout port on the responder so that its tri-state driver stays
// local to the block that owns it.
interface h80bus_timer_if #(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3
);
    logic                      en_n;
    logic [BUS_ADDR_WIDTH-1:0] bus_addr;
    logic [BUS_CMD_WIDTH-1:0]  bus_cmd;
    logic                      wait_n;

    modport master (
        output en_n,
        output bus_addr,
        output bus_cmd,
        input  wait_n
    );

    modport slave (
        input  en_n,
        input  bus_addr,
        input  bus_cmd,
        output wait_n
    );
endinterface

// File: rtl/h80bus_timer.sv
// h80bus_timer: memory-mapped down-counting timer responding in the h80bus
// I/O space. Provides CTRL/STATUS/LOAD/COUNT/PRESCALE registers, a sticky
// expiry flag, a registered level interrupt, and read wait-state insertion.
module h80bus_timer #(
    parameter int                        BUS_ADDR_WIDTH = 16,
    parameter int                        BUS_CMD_WIDTH  = 3,
    parameter int                        BUS_DATA_WIDTH = 32,
    parameter logic [BUS_ADDR_WIDTH-1:0] BASE_ADDR      = 16'h0010,
    parameter int                        RD_WAIT_STATES = 1,
    parameter logic [BUS_CMD_WIDTH-1:0]  BUS_CMD_READ   = 3'd1,
    parameter logic [BUS_CMD_WIDTH-1:0]  BUS_CMD_WRITE  = 3'd2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    h80bus_timer_if.slave             bus,
    inout  wire  [BUS_DATA_WIDTH-1:0] bus_data,
    output logic                      irq
);

    localparam int WCNT_W = (RD_WAIT_STATES > 1) ? $clog2(RD_WAIT_STATES) : 1;

    localparam logic [3:0] OFF_CTRL     = 4'd0;
    localparam logic [3:0] OFF_STATUS   = 4'd1;
    localparam logic [3:0] OFF_LOAD     = 4'd2;
    localparam logic [3:0] OFF_COUNT    = 4'd3;
    localparam logic [3:0] OFF_PRESCALE = 4'd4;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        DONE
    } state_t;

    state_t                     state;
    logic [WCNT_W-1:0]          wcnt;
    logic [BUS_DATA_WIDTH-1:0]  rdata;

    logic [2:0]                 ctrl;
    logic                       exp_flag;
    logic [BUS_DATA_WIDTH-1:0]  load;
    logic [BUS_DATA_WIDTH-1:0]  count;
    logic [15:0]                prescale;
    logic [15:0]                psc;

    logic                       ctrl_en;
    logic                       ctrl_auto;
    logic                       ctrl_ie;

    logic                       sel;
    logic [3:0]                 offset;
    logic                       is_rd;
    logic                       is_wr;
    logic                       wr_en;
    logic                       wr_ctrl;
    logic                       wr_status;
    logic                       wr_load;
    logic                       wr_count;
    logic                       wr_prescale;
    logic                       tick;
    logic                       expire;
    logic                       drive;
    logic [BUS_DATA_WIDTH-1:0]  rd_mux;

    assign ctrl_en   = ctrl[0];
    assign ctrl_auto = ctrl[1];
    assign ctrl_ie   = ctrl[2];

    // Address decode: the window is the 16-byte block at BASE_ADDR.
    assign sel    = !bus.en_n && (bus.bus_addr[BUS_ADDR_WIDTH-1:4] == BASE_ADDR[BUS_ADDR_WIDTH-1:4]);
    assign offset = bus.bus_addr[3:0];
    assign is_rd  = (bus.bus_cmd == BUS_CMD_READ);
    assign is_wr  = (bus.bus_cmd == BUS_CMD_WRITE);

    // A write is taken exactly once, on the first edge of the access.
    assign wr_en       = (state == IDLE) && sel && is_wr;
    assign wr_ctrl     = wr_en && (offset == OFF_CTRL);
    assign wr_status   = wr_en && (offset == OFF_STATUS);
    assign wr_load     = wr_en && (offset == OFF_LOAD);
    assign wr_count    = wr_en && (offset == OFF_COUNT);
    assign wr_prescale = wr_en && (offset == OFF_PRESCALE);

    assign tick   = ctrl_en && (psc == prescale);
    assign expire = tick && (count == '0);

    // Gating with reset_n makes the block release the bus the instant reset
    // is asserted, even while the CPU still holds the access open.
    assign bus.wait_n = !(reset_n && sel && is_rd && ((state == IDLE) || (state == RD_WAIT)));
    assign drive      = reset_n && sel && is_rd && ((state == RD_DRIVE) || (state == DONE));
    assign bus_data   = drive ? rdata : {BUS_DATA_WIDTH{1'bz}};

    // Register read multiplexer; unmapped offsets and unused bits read 0.
    always_comb begin
        rd_mux = '0;
        case (offset)
            OFF_CTRL:     rd_mux = {{(BUS_DATA_WIDTH-3){1'b0}}, ctrl};
            OFF_STATUS:   rd_mux = {{(BUS_DATA_WIDTH-1){1'b0}}, exp_flag};
            OFF_LOAD:     rd_mux = load;
            OFF_COUNT:    rd_mux = count;
            OFF_PRESCALE: rd_mux = {{(BUS_DATA_WIDTH-16){1'b0}}, prescale};
            default:      rd_mux = '0;
        endcase
    end

    // Bus access FSM: read wait-state sequencing, capture and abort handling.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            wcnt  <= '0;
            rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel) begin
                        if (is_rd) begin
                            wcnt  <= WCNT_W'(RD_WAIT_STATES - 1);
                            state <= RD_WAIT;
                        end else begin
                            // Writes complete here; unknown commands are no-ops.
                            state <= DONE;
                        end
                    end
                end
                RD_WAIT: begin
                    if (bus.en_n) begin
                        state <= IDLE;
                    end else if (wcnt == '0) begin
                        rdata <= rd_mux;
                        state <= RD_DRIVE;
                    end else begin
                        wcnt <= wcnt - WCNT_W'(1);
                    end
                end
                RD_DRIVE: begin
                    state <= bus.en_n ? IDLE : DONE;
                end
                DONE: begin
                    if (bus.en_n) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Prescaler: free-runs 0..PRESCALE while enabled, parked at 0 otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            psc <= '0;
        end else if (wr_ctrl && bus_data[0] && !ctrl_en) begin
            psc <= '0;
        end else if (!ctrl_en || (psc == prescale)) begin
            psc <= '0;
        end else begin
            psc <= psc + 16'd1;
        end
    end

    // CTRL: bus write has priority over the one-shot auto-disable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl <= '0;
        end else if (wr_ctrl) begin
            ctrl <= bus_data[2:0];
        end else if (expire && !ctrl_auto) begin
            ctrl[0] <= 1'b0;
        end
    end

    // COUNT: bus write has priority over the tick decrement/reload.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (wr_count) begin
            count <= bus_data;
        end else if (tick) begin
            if (count != '0) begin
                count <= count - BUS_DATA_WIDTH'(1);
            end else if (ctrl_auto) begin
                count <= load;
            end
        end
    end

    // EXP: sticky; a new expiry wins over a simultaneous write-1-to-clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exp_flag <= 1'b0;
        end else if (expire) begin
            exp_flag <= 1'b1;
        end else if (wr_status && bus_data[0]) begin
            exp_flag <= 1'b0;
        end
    end

    // LOAD and PRESCALE: plain bus-writable configuration registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            load     <= '0;
            prescale <= '0;
        end else begin
            if (wr_load) begin
                load <= bus_data;
            end
            if (wr_prescale) begin
                prescale <= bus_data[15:0];
            end
        end
    end

    // Interrupt: registered copy of EXP gated by IE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else begin
            irq <= exp_flag && ctrl_ie;
        end
    end

endmodule

// File: tb/tb_h80bus_timer.sv
// Self-checking bench for h80bus_timer: directed scenarios followed by a
// randomized register-access phase, all checked against a register-level
// behavioural model of the timer.
module tb_h80bus_timer;

    localparam int          AW        = 16;
    localparam int          CW        = 3;
    localparam int          DW        = 32;
    localparam logic [15:0] BASE_ADDR = 16'h0010;
    localparam int          RWS       = 1;
    localparam logic [2:0]  CMD_RD    = 3'd1;
    localparam logic [2:0]  CMD_WR    = 3'd2;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          irq;
    wire  [DW-1:0] bus_data;
    logic          tb_drive;
    logic [DW-1:0] tb_wdata;

    int vectors     = 0;
    int miscompares = 0;
    int cycle_no    = 0;

    // Behavioural model state: architectural registers as seen by software.
    bit [2:0]  m_ctrl;
    bit        m_exp;
    bit [31:0] m_load;
    bit [31:0] m_count;
    bit [15:0] m_pre;
    bit [15:0] m_psc;
    bit        m_irq;

    // Write landing on the next clock edge, as seen by the model.
    bit        wr_now;
    bit [3:0]  wr_off;
    bit [31:0] wr_dat;

    assign bus_data = tb_drive ? tb_wdata : 'z;

    h80bus_timer_if #(.BUS_ADDR_WIDTH(AW), .BUS_CMD_WIDTH(CW)) bus_if ();

    h80bus_timer #(
        .BUS_ADDR_WIDTH(AW),
        .BUS_CMD_WIDTH (CW),
        .BUS_DATA_WIDTH(DW),
        .BASE_ADDR     (BASE_ADDR),
        .RD_WAIT_STATES(RWS),
        .BUS_CMD_READ  (CMD_RD),
        .BUS_CMD_WRITE (CMD_WR)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if.slave),
        .bus_data(bus_data),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp_v);
        end
    endtask

    function automatic bit is_float(input logic [31:0] v);
        return $isunknown(v) || (v == 32'h0);
    endfunction

    function automatic bit [31:0] m_read(input bit [3:0] off);
        case (off)
            4'd0:    return {29'b0, m_ctrl};
            4'd1:    return {31'b0, m_exp};
            4'd2:    return m_load;
            4'd3:    return m_count;
            4'd4:    return {16'b0, m_pre};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_ctrl = '0; m_exp = 1'b0; m_load = '0; m_count = '0;
        m_pre = '0; m_psc = '0; m_irq = 1'b0;
    endtask

    // One clock of timer behaviour from the register-level rules.
    task automatic model_step();
        bit en, tick, expire;
        en     = m_ctrl[0];
        tick   = en && (m_psc == m_pre);
        expire = tick && (m_count == 0);
        m_irq  = m_exp && m_ctrl[2];
        m_psc  = (!en || tick) ? 16'd0 : m_psc + 16'd1;
        if (wr_now && wr_off == 4'd3) m_count = wr_dat;
        else if (tick && m_count != 0) m_count = m_count - 1;
        else if (expire && m_ctrl[1]) m_count = m_load;
        if (expire) m_exp = 1'b1;
        else if (wr_now && wr_off == 4'd1 && wr_dat[0]) m_exp = 1'b0;
        if (wr_now && wr_off == 4'd0) m_ctrl = wr_dat[2:0];
        else if (expire && !m_ctrl[1]) m_ctrl[0] = 1'b0;
        if (wr_now && wr_off == 4'd2) m_load = wr_dat;
        if (wr_now && wr_off == 4'd4) m_pre = wr_dat[15:0];
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        cycle_no++;
        @(negedge clk);
        check("irq", 32'(irq), 32'(m_irq));
    endtask

    task automatic bus_write(input bit [3:0] off, input bit [31:0] d);
        bus_if.en_n     = 1'b0;
        bus_if.bus_addr = BASE_ADDR | {12'b0, off};
        bus_if.bus_cmd  = CMD_WR;
        tb_drive = 1'b1; tb_wdata = d;
        wr_now = 1'b1; wr_off = off; wr_dat = d;
        #1;
        check("wr_wait_n", 32'(bus_if.wait_n), 32'd1);
        cyc();
        wr_now = 1'b0;
        bus_if.en_n = 1'b1; bus_if.bus_cmd = 3'd0; tb_drive = 1'b0;
        cyc();
    endtask

    task automatic bus_read(input bit [3:0] off, input string tag, output bit [31:0] val);
        bit [31:0] exp_val;
        int n;
        bus_if.en_n     = 1'b0;
        bus_if.bus_addr = BASE_ADDR | {12'b0, off};
        bus_if.bus_cmd  = CMD_RD;
        n = 0; exp_val = '0;
        #1;
        while (bus_if.wait_n === 1'b0 && n < 20) begin
            exp_val = m_read(off);
            n++;
            cyc();
            #1;
        end
        check({tag, "_waits"}, 32'(n), 32'(RWS + 1));
        check({tag, "_data"}, bus_data, exp_val);
        val = bus_data;
        bus_if.en_n = 1'b1; bus_if.bus_cmd = 3'd0;
        cyc();
        check({tag, "_release"}, 32'(is_float(bus_data)), 32'd1);
    endtask

    task automatic foreign(input string tag, input logic [15:0] a, input logic [2:0] c,
                           input logic e, input logic drv, input logic [31:0] d);
        bus_if.en_n = e; bus_if.bus_addr = a; bus_if.bus_cmd = c;
        tb_drive = drv; tb_wdata = d;
        #1;
        for (int i = 0; i < 3; i++) begin
            check({tag, "_wait_n"}, 32'(bus_if.wait_n), 32'd1);
            if (!drv) check({tag, "_float"}, 32'(is_float(bus_data)), 32'd1);
            cyc();
        end
        bus_if.en_n = 1'b1; bus_if.bus_cmd = 3'd0; tb_drive = 1'b0;
        cyc();
        check({tag, "_after"}, 32'(is_float(bus_data)), 32'd1);
    endtask

    task automatic wait_irq(input string tag, output int t);
        int n;
        n = 0;
        while (irq !== 1'b1 && n < 40) begin
            cyc();
            n++;
        end
        check({tag, "_irq_rise"}, 32'(irq), 32'd1);
        t = cycle_no;
    endtask

    initial begin
        bit [31:0] v;
        bit [3:0]  off;
        bit [31:0] d;
        int        t1, t2, t3, n;

        reset_n = 1'b0;
        bus_if.en_n = 1'b1; bus_if.bus_addr = '0; bus_if.bus_cmd = 3'd0;
        tb_drive = 1'b0; tb_wdata = '0;
        wr_now = 1'b0; wr_off = '0; wr_dat = '0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_wait_n", 32'(bus_if.wait_n), 32'd1);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_float", 32'(is_float(bus_data)), 32'd1);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus_read(4'(i), "rst_reg", v);
            check("rst_reg_zero", v, 32'h0);
        end

        // Write/read round trip and unmapped offset
        bus_write(4'd2, 32'h1234_5678);
        bus_read(4'd2, "rt_load", v);
        check("rt_load_val", v, 32'h1234_5678);
        bus_read(4'd9, "rt_off9", v);
        check("rt_off9_zero", v, 32'h0);

        // One-shot: 4th tick expires, irq follows one cycle later
        bus_write(4'd4, 32'd0);
        bus_write(4'd3, 32'd3);
        bus_write(4'd0, 32'd5);
        n = 0;
        while (irq !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        check("os_irq_latency", 32'(n), 32'd4);
        repeat (4) cyc();
        bus_read(4'd1, "os_status", v);
        check("os_status_val", v, 32'h1);
        bus_read(4'd0, "os_ctrl", v);
        check("os_ctrl_val", v, 32'h4);
        bus_read(4'd3, "os_count", v);
        check("os_count_val", v, 32'h0);

        // Auto-reload: EXP every 6 cycles with PRESCALE=1, LOAD=2
        bus_write(4'd0, 32'd0);
        bus_write(4'd1, 32'd1);
        bus_write(4'd4, 32'd1);
        bus_write(4'd2, 32'd2);
        bus_write(4'd3, 32'd0);
        bus_write(4'd0, 32'd7);
        wait_irq("ar1", t1);
        bus_write(4'd1, 32'd1);
        check("ar_irq_cleared", 32'(irq), 32'd0);
        wait_irq("ar2", t2);
        check("ar_period1", 32'(t2 - t1), 32'd6);
        bus_write(4'd1, 32'd1);
        wait_irq("ar3", t3);
        check("ar_period2", 32'(t3 - t2), 32'd6);

        // Set and clear of EXP on the same edge: set wins
        n = 0;
        while (!(m_ctrl[0] && m_psc == m_pre && m_count == 0) && n < 20) begin
            cyc();
            n++;
        end
        bus_write(4'd1, 32'd1);
        bus_read(4'd1, "ar_collide", v);
        check("ar_collide_exp", v, 32'h1);

        // COUNT write on a tick edge: the write wins
        bus_write(4'd0, 32'd0);
        bus_write(4'd4, 32'd20);
        bus_write(4'd3, 32'd500);
        bus_write(4'd0, 32'd1);
        n = 0;
        while (!(m_ctrl[0] && m_psc == m_pre) && n < 50) begin
            cyc();
            n++;
        end
        bus_write(4'd3, 32'd100);
        bus_write(4'd0, 32'd0);
        bus_read(4'd3, "wt_count", v);
        check("wt_count_val", v, 32'd100);

        // Address window, deasserted request, unknown command
        bus_write(4'd2, 32'hA5A5_0F0F);
        bus_read(4'd2, "win_pre", v);
        foreign("win_out_rd", 16'h0020, CMD_RD, 1'b0, 1'b0, 32'h0);
        foreign("win_out_wr", 16'h0022, CMD_WR, 1'b0, 1'b1, 32'h1111_1111);
        foreign("win_en_rd", BASE_ADDR | 16'd2, CMD_RD, 1'b1, 1'b0, 32'h0);
        foreign("win_en_wr", BASE_ADDR | 16'd2, CMD_WR, 1'b1, 1'b1, 32'h2222_2222);
        foreign("win_nop", BASE_ADDR | 16'd2, 3'd0, 1'b0, 1'b0, 32'h0);
        bus_read(4'd2, "win_post", v);
        check("win_load_kept", v, 32'hA5A5_0F0F);

        // Read aborted during the wait phase
        bus_if.en_n = 1'b0; bus_if.bus_addr = BASE_ADDR | 16'd2; bus_if.bus_cmd = CMD_RD;
        #1;
        check("abort_wait_lo", 32'(bus_if.wait_n), 32'd0);
        cyc();
        bus_if.en_n = 1'b1;
        #1;
        check("abort_wait_hi", 32'(bus_if.wait_n), 32'd1);
        bus_if.bus_cmd = 3'd0;
        cyc();
        check("abort_float", 32'(is_float(bus_data)), 32'd1);
        bus_read(4'd2, "abort_next", v);

        // Randomized register traffic
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    off = 4'($urandom_range(0, 6));
                    case (off)
                        4'd2, 4'd3: d = $urandom_range(0, 12);
                        4'd4:       d = ($urandom & 32'hFFFF_0000) | $urandom_range(0, 3);
                        default:    d = $urandom;
                    endcase
                    bus_write(off, d);
                end
                4, 5, 6: begin
                    off = 4'($urandom_range(0, 15));
                    bus_read(off, "rnd_rd", v);
                end
                default: begin
                    repeat ($urandom_range(1, 4)) cyc();
                end
            endcase
        end

        // Reset asserted while a read is driving the bus
        bus_write(4'd4, 32'd0);
        bus_write(4'd3, 32'd0);
        bus_write(4'd2, 32'hDEAD_BEEF);
        bus_write(4'd0, 32'd5);
        repeat (3) cyc();
        check("pre_rst_irq", 32'(irq), 32'd1);
        bus_if.en_n = 1'b0; bus_if.bus_addr = BASE_ADDR | 16'd2; bus_if.bus_cmd = CMD_RD;
        cyc();
        cyc();
        check("mid_rd_data", bus_data, 32'hDEAD_BEEF);
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_wait_n", 32'(bus_if.wait_n), 32'd1);
        check("mid_rst_float", 32'(is_float(bus_data)), 32'd1);
        check("mid_rst_irq", 32'(irq), 32'd0);
        bus_if.en_n = 1'b1; bus_if.bus_cmd = 3'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus_read(4'(i), "post_rst_reg", v);
            check("post_rst_zero", v, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
